// File: rtl/fighter_action_sequencer.sv
// Turns debounced per-player button pulses into timed punch/kick/special actions
// with cooldown lockout, combo-window arming and idle-only movement pass-through.
module fighter_action_sequencer #(
  parameter int unsigned COMBO_WIN    = 8,
  parameter int unsigned PUNCH_LEN    = 4,
  parameter int unsigned KICK_LEN     = 6,
  parameter int unsigned SPECIAL_LEN  = 10,
  parameter int unsigned COOLDOWN_LEN = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FACING,
  input  logic       LEFT_P,
  input  logic       RIGHT_P,
  input  logic       PUNCH_P,
  input  logic       KICK_P,
  output logic [2:0] ACTION,
  output logic       ACTION_START,
  output logic       BUSY,
  output logic       MOVE_L,
  output logic       MOVE_R
);

  typedef enum logic [1:0] {IDLE, ATTACK, COOLDOWN} state_t;
  typedef enum logic [2:0] {
    ACT_NONE    = 3'd0,
    ACT_PUNCH   = 3'd1,
    ACT_KICK    = 3'd2,
    ACT_SPECIAL = 3'd3
  } action_t;

  state_t     state_q, state_d;
  action_t    action_q, action_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] win_q, win_d;
  logic       armed_q, armed_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d;
  logic       move_l_q, move_l_d;
  logic       move_r_q, move_r_d;
  logic       fwd_p, bwd_p;

  assign fwd_p = FACING ? RIGHT_P : LEFT_P;
  assign bwd_p = FACING ? LEFT_P : RIGHT_P;

  always_comb begin
    state_d  = state_q;
    action_d = action_q;
    phase_d  = phase_q;
    win_d    = (win_q != '0) ? win_q - 8'd1 : '0;
    // Armed expires after the cycle in which the window counter reads 1,
    // giving exactly COMBO_WIN armed cycles after the forward pulse.
    armed_d  = armed_q && (win_q > 8'd1);
    start_d  = 1'b0;
    move_l_d = 1'b0;
    move_r_d = 1'b0;

    case (state_q)
      IDLE: begin
        action_d = ACT_NONE;
        if (PUNCH_P) begin
          state_d = ATTACK;
          start_d = 1'b1;
          armed_d = 1'b0;
          if (armed_q) begin
            action_d = ACT_SPECIAL;
            phase_d  = 8'(SPECIAL_LEN);
          end else begin
            action_d = ACT_PUNCH;
            phase_d  = 8'(PUNCH_LEN);
          end
        end else if (KICK_P) begin
          state_d  = ATTACK;
          start_d  = 1'b1;
          armed_d  = 1'b0;
          action_d = ACT_KICK;
          phase_d  = 8'(KICK_LEN);
        end else if (LEFT_P && RIGHT_P) begin
          armed_d = 1'b0;
        end else if (fwd_p) begin
          armed_d  = 1'b1;
          win_d    = 8'(COMBO_WIN);
          move_l_d = LEFT_P;
          move_r_d = RIGHT_P;
        end else if (bwd_p) begin
          armed_d  = 1'b0;
          move_l_d = LEFT_P;
          move_r_d = RIGHT_P;
        end
      end
      ATTACK: begin
        if (phase_q <= 8'd1) begin
          action_d = ACT_NONE;
          if (COOLDOWN_LEN == 0) begin
            state_d = IDLE;
            phase_d = '0;
          end else begin
            state_d = COOLDOWN;
            phase_d = 8'(COOLDOWN_LEN);
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      COOLDOWN: begin
        action_d = ACT_NONE;
        if (phase_q <= 8'd1) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        action_d = ACT_NONE;
        phase_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      action_q <= ACT_NONE;
      phase_q  <= '0;
      win_q    <= '0;
      armed_q  <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      move_l_q <= 1'b0;
      move_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      action_q <= action_d;
      phase_q  <= phase_d;
      win_q    <= win_d;
      armed_q  <= armed_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      move_l_q <= move_l_d;
      move_r_q <= move_r_d;
    end
  end

  assign ACTION       = action_q;
  assign ACTION_START = start_q;
  assign BUSY         = busy_q;
  assign MOVE_L       = move_l_q;
  assign MOVE_R       = move_r_q;

endmodule

// File: tb/tb_fighter_action_sequencer.sv
// Directed scoreboard bench: each driven pulse queues the per-cycle outputs it must
// produce; every cycle the head entry (or all-zero idle) is compared.
module tb_fighter_action_sequencer;

  localparam int unsigned CW  = 8;
  localparam int unsigned PL  = 4;
  localparam int unsigned KL  = 6;
  localparam int unsigned SL  = 10;
  localparam int unsigned CDL = 3;

  logic       clk = 1'b0;
  logic       rst, facing, left_p, right_p, punch_p, kick_p;
  logic [2:0] action;
  logic       action_start, busy, move_l, move_r;

  fighter_action_sequencer #(
    .COMBO_WIN   (CW),
    .PUNCH_LEN   (PL),
    .KICK_LEN    (KL),
    .SPECIAL_LEN (SL),
    .COOLDOWN_LEN(CDL)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .FACING      (facing),
    .LEFT_P      (left_p),
    .RIGHT_P     (right_p),
    .PUNCH_P     (punch_p),
    .KICK_P      (kick_p),
    .ACTION      (action),
    .ACTION_START(action_start),
    .BUSY        (busy),
    .MOVE_L      (move_l),
    .MOVE_R      (move_r)
  );

  always #5 clk = ~clk;

  // v = {action[2:0], start, busy, move_l, move_r}
  typedef struct {
    int unsigned cyc;
    logic [6:0]  v;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          chk    = 1'b0;

  task automatic tick();
    exp_t       e;
    logic [6:0] obs;
    @(posedge clk);
    #1;
    cyc++;
    if (chk) begin
      e.cyc = cyc;
      e.v   = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) e = sb.pop_front();
      obs = {action, action_start, busy, move_l, move_r};
      checks++;
      assert (obs === e.v)
      else begin
        errors++;
        $error("FAIL out@%0d act/st/bsy/ml/mr observed %b expected %b", cyc, obs, e.v);
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Drive one cycle of pulses and queue what they must produce.
  // code: attack the bench expects to be accepted (0 = none); ml/mr: expected moves.
  task automatic drive(input logic l, input logic r, input logic p, input logic k,
                       input logic [2:0] code, input logic ml, input logic mr);
    exp_t        e;
    int unsigned len;
    left_p  = l;
    right_p = r;
    punch_p = p;
    kick_p  = k;
    if (code != 3'd0) begin
      len = (code == 3'd1) ? PL : (code == 3'd2) ? KL : SL;
      for (int unsigned i = 1; i <= len + CDL; i++) begin
        e.cyc = cyc + i;
        e.v   = {(i <= len) ? code : 3'd0, (i == 1) ? 1'b1 : 1'b0, 1'b1, 2'b00};
        sb.push_back(e);
      end
    end
    if (ml || mr) begin
      e.cyc = cyc + 1;
      e.v   = {3'd0, 1'b0, 1'b0, ml, mr};
      sb.push_back(e);
    end
    tick();
    left_p  = 1'b0;
    right_p = 1'b0;
    punch_p = 1'b0;
    kick_p  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; facing = 1'b1;
    left_p = 1'b0; right_p = 1'b0; punch_p = 1'b0; kick_p = 1'b0;

    // Reset held two cycles, then 20 quiet cycles
    tick();
    chk = 1'b1;
    tick();
    rst = 1'b0;
    idle(20);

    // Punch, ignored punch during lockout, back-to-back kick in first idle cycle
    drive(0, 0, 1, 0, 3'd1, 0, 0);
    idle(2);
    drive(0, 0, 1, 0, 3'd0, 0, 0);
    idle(4);
    drive(0, 0, 0, 1, 3'd2, 0, 0);
    idle(12);

    // Special at the last armed cycle
    drive(0, 1, 0, 0, 3'd0, 0, 1);
    idle(CW - 1);
    drive(0, 0, 1, 0, 3'd3, 0, 0);
    idle(15);

    // One cycle past the window
    drive(0, 1, 0, 0, 3'd0, 0, 1);
    idle(CW);
    drive(0, 0, 1, 0, 3'd1, 0, 0);
    idle(10);

    // Forward pulse and punch in the same cycle: punch, no arming
    drive(0, 1, 1, 0, 3'd1, 0, 0);
    idle(PL + CDL);
    drive(0, 0, 1, 0, 3'd1, 0, 0);
    idle(10);

    // Facing left: right is backward, left is forward
    facing = 1'b0;
    drive(0, 1, 0, 0, 3'd0, 0, 1);
    idle(1);
    drive(0, 0, 1, 0, 3'd1, 0, 0);
    idle(10);
    drive(1, 0, 0, 0, 3'd0, 1, 0);
    idle(1);
    drive(0, 0, 1, 0, 3'd3, 0, 0);
    idle(15);
    drive(1, 0, 0, 0, 3'd0, 1, 0);
    idle(1);
    drive(0, 1, 0, 0, 3'd0, 0, 1);
    idle(1);
    drive(0, 0, 1, 0, 3'd1, 0, 0);
    idle(10);

    // Simultaneous pulses
    facing = 1'b1;
    drive(0, 0, 1, 1, 3'd1, 0, 0);
    idle(8);
    drive(1, 0, 0, 1, 3'd2, 0, 0);
    idle(10);
    drive(1, 1, 0, 0, 3'd0, 0, 0);
    idle(2);
    drive(0, 1, 0, 0, 3'd0, 0, 1);
    drive(1, 1, 0, 0, 3'd0, 0, 0);
    drive(0, 0, 1, 0, 3'd1, 0, 0);
    idle(10);

    // Reset during ATTACK cycle 5 of a special
    drive(0, 1, 0, 0, 3'd0, 0, 1);
    idle(2);
    drive(0, 0, 1, 0, 3'd3, 0, 0);
    idle(4);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    drive(0, 0, 1, 0, 3'd1, 0, 0);
    idle(10);

    // Reset clears an armed window
    drive(0, 1, 0, 0, 3'd0, 0, 1);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    drive(0, 0, 1, 0, 3'd1, 0, 0);
    idle(12);

    checks++;
    assert (sb.size() === 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fighter_action_sequencer.md
# fighter_action_sequencer

Converts debounced single-cycle button pulses for one player into timed fighter actions: punch, kick, and a forward+punch special. It sits directly downstream of the per-button input debouncers, one per player, and drives the sprite/animation and hit-detection logic with an action code, a start pulse and a busy flag. Movement pulses pass through only while the fighter is idle.

## Interface
- `COMBO_WIN`, default 8: cycles after a forward pulse in which PUNCH becomes SPECIAL (1..255).
- `PUNCH_LEN`, default 4: ATTACK duration for a punch, in cycles (1..255).
- `KICK_LEN`, default 6: ATTACK duration for a kick (1..255).
- `SPECIAL_LEN`, default 10: ATTACK duration for a special (1..255).
- `COOLDOWN_LEN`, default 3: recovery cycles after any attack (0..255).

- `CLK` in 1: system clock, shared with the debouncers.
- `RESET` in 1: synchronous, active-high reset.
- `FACING` in 1: 1 = facing right, 0 = facing left. Level signal, sampled every cycle.
- `LEFT_P`, `RIGHT_P`, `PUNCH_P`, `KICK_P` in 1 each: debounced single-cycle pulses.
- `ACTION` out 3: 0 = NONE, 1 = PUNCH, 2 = KICK, 3 = SPECIAL. Codes 4..7 are never driven.
- `ACTION_START` out 1: one-cycle pulse on the first cycle of an attack.
- `BUSY` out 1: high whenever state ≠ IDLE.
- `MOVE_L`, `MOVE_R` out 1 each: one-cycle movement pulses.

## Operation
- **States.** IDLE, ATTACK, COOLDOWN. An 8-bit phase counter and an 8-bit combo-window counter with an armed flag support them. All outputs are registered.
- **Forward pulse.** This is `RIGHT_P` when FACING=1 and `LEFT_P` when FACING=0. The other direction is the backward pulse.
- **IDLE decode.** Priority is PUNCH_P > KICK_P > direction.
  - PUNCH_P with armed=1: go to ATTACK with code 3, length SPECIAL_LEN.
  - PUNCH_P with armed=0: code 1, length PUNCH_LEN.
  - KICK_P: code 2, length KICK_LEN.
  - Accepting any attack clears armed. Direction pulses in the same cycle are dropped: no MOVE, no arming.
  - With no attack pulse, `LEFT_P` produces `MOVE_L` and `RIGHT_P` produces `MOVE_R`.
  - A forward pulse arms the combo and loads the window counter with COMBO_WIN; a repeated forward pulse reloads it. A backward pulse clears armed.
  - LEFT_P and RIGHT_P in the same cycle: both MOVE outputs are 0 and armed is cleared.
- **Combo window.** The armed flag covers exactly cycles f+1..f+COMBO_WIN, where f is the cycle of the forward pulse. The window counter decrements every cycle, including outside IDLE.
- **ATTACK.**
  - `ACTION` holds the code for the attack length, then the block enters COOLDOWN.
  - If COOLDOWN_LEN=0, it goes directly to IDLE.
- **COOLDOWN.** Lasts COOLDOWN_LEN cycles, then IDLE.
- **Inputs outside IDLE.** Every input pulse received in ATTACK or COOLDOWN is discarded, not buffered.
- **FACING changes.** They take effect on the next pulse. An existing armed state is kept.
- **Reset.** `RESET` has priority over all other logic, at any point including mid-attack. Next cycle:
  - state = IDLE, armed = 0, counters = 0;
  - `ACTION`=0, `ACTION_START`=0, `BUSY`=0, `MOVE_L`=0, `MOVE_R`=0.

## Timing
- **Attack latency.** An attack pulse accepted at cycle n gives:
  - `ACTION_START`=1 at n+1 only;
  - `ACTION`=code during n+1..n+LEN;
  - `BUSY`=1 during n+1..n+LEN+COOLDOWN_LEN;
  - state = IDLE at n+LEN+COOLDOWN_LEN+1, where a pulse is accepted.
- **Movement latency.** A movement pulse at cycle n gives `MOVE_x`=1 at n+1 only.
- **Back-to-back.** An attack pulse arriving in the first IDLE cycle is accepted with no gap cycle. `ACTION_START` may therefore follow the previous attack's last `BUSY` cycle directly.
- **Window edges.** Forward at f, punch at f+COMBO_WIN gives SPECIAL. Punch at f+COMBO_WIN+1 gives PUNCH. Punch at f (same cycle) gives PUNCH, and arming is dropped.

## Test plan
Defaults apply, FACING=1 unless stated.
1. **Reset.** Hold RESET for 2 cycles, then release with no input. Required: all outputs 0 and state IDLE for 20 cycles.
2. **Punch and lockout.** PUNCH_P at cycle 10. Required: ACTION_START at 11; ACTION=1 for 11–14; BUSY for 11–17. A PUNCH_P at 13 is ignored. A KICK_P at 18 gives ACTION=2 for 19–24.
3. **Special at window edge.** RIGHT_P at 20, PUNCH_P at 28. Required: MOVE_R at 21; ACTION=3 for 29–38; BUSY until 41.
4. **Window miss and facing.**
   - RIGHT_P at 20, PUNCH_P at 29: ACTION=1, not 3.
   - FACING=0, RIGHT_P at 50, PUNCH_P at 52: ACTION=1.
   - FACING=0, LEFT_P at 60, RIGHT_P at 62, PUNCH_P at 64: ACTION=1, because the backward pulse disarms.
5. **Simultaneous pulses.**
   - PUNCH_P and KICK_P in the same cycle: ACTION=1.
   - KICK_P and LEFT_P in the same cycle: ACTION=2, no MOVE_L.
   - LEFT_P and RIGHT_P in the same cycle: no MOVE outputs.
6. **Reset mid-attack.** RIGHT_P, PUNCH_P 3 cycles later, then RESET during ATTACK cycle 5. Required: all outputs 0 the next cycle. A PUNCH_P after reset gives ACTION=1, because armed was cleared.
